// File: rtl/uart_alu_pkg.sv
// Shared opcodes, framing constants and FSM state type for the UART packet ALU.
package uart_alu_pkg;

    localparam logic [7:0] OP_ECHO  = 8'hEC;
    localparam logic [7:0] OP_ADD   = 8'hAD;
    localparam logic [7:0] OP_MUL   = 8'h88;
    localparam logic [7:0] ERR_BYTE = 8'hEE;

    localparam int HDR_BYTES = 4;

    // Serializer mode: a single byte (echo, error) or a full result word.
    localparam logic [7:0] MODE_BYTE = 8'h00;
    localparam logic [7:0] MODE_WORD = 8'h01;

    typedef enum logic [3:0] {
        IDLE_OP,
        RSVD,
        LEN_LO,
        LEN_HI,
        ECHO,
        OPERAND,
        SEND_RES,
        SEND_ERR,
        DRAIN
    } state_e;

    function automatic int bytes_per_op(input int width);
        return width / 8;
    endfunction

endpackage

// File: rtl/uart_alu_tx_ser.sv
// Output serializer: loads a word (or one byte) and streams it LSB-first onto the
// byte handshake; done pulses on the final accepted byte.
module uart_alu_tx_ser
    import uart_alu_pkg::*;
#(
    parameter int WIDTH_P = 32
) (
    input  logic               clk_i,
    input  logic               reset_ni,
    input  logic               load,
    input  logic [WIDTH_P-1:0] word,
    input  logic [7:0]         mode,
    output logic               ready,
    output logic               done,
    output logic [7:0]         m_axis_tdata,
    output logic               m_axis_tvalid,
    input  logic               m_axis_tready
);

    localparam int NB = bytes_per_op(WIDTH_P);

    logic [WIDTH_P-1:0] shift_reg;
    logic [3:0]         left_reg;
    logic [7:0]         tdata_reg;
    logic               tvalid_reg;
    logic               fire;

    assign fire  = tvalid_reg && m_axis_tready;
    assign done  = fire && (left_reg == 4'd0);
    // A new load may overlap the acceptance of the last pending byte.
    assign ready = !tvalid_reg || done;

    assign m_axis_tdata  = tdata_reg;
    assign m_axis_tvalid = tvalid_reg;

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            shift_reg  <= '0;
            left_reg   <= 4'd0;
            tdata_reg  <= 8'h00;
            tvalid_reg <= 1'b0;
        end else if (load && ready) begin
            tdata_reg  <= word[7:0];
            shift_reg  <= word >> 8;
            left_reg   <= (mode == MODE_WORD) ? 4'(NB - 1) : 4'd0;
            tvalid_reg <= 1'b1;
        end else if (fire) begin
            if (left_reg == 4'd0) begin
                tvalid_reg <= 1'b0;
            end else begin
                tdata_reg <= shift_reg[7:0];
                shift_reg <= shift_reg >> 8;
                left_reg  <= left_reg - 4'd1;
            end
        end
    end

endmodule

// File: rtl/uart_alu_core.sv
// Framed-packet ALU between UART RX and TX streams: echo, multi-operand add or
// multiply at WIDTH_P bits; malformed packets answer with a single error byte.
module uart_alu_core
    import uart_alu_pkg::*;
#(
    parameter int WIDTH_P   = 32,
    parameter int MAX_LEN_P = 65535
) (
    input  logic       clk_i,
    input  logic       reset_ni,
    input  logic [7:0] s_axis_tdata,
    input  logic       s_axis_tvalid,
    output logic       s_axis_tready,
    output logic [7:0] m_axis_tdata,
    output logic       m_axis_tvalid,
    input  logic       m_axis_tready,
    output logic       busy_o,
    output logic       err_o
);

    localparam int          NB        = bytes_per_op(WIDTH_P);
    localparam logic [15:0] NB_W      = 16'(NB);
    localparam logic [3:0]  NB_LAST   = 4'(NB - 1);
    localparam logic [15:0] MAX_LEN_W = 16'(MAX_LEN_P);
    localparam logic [15:0] HDR_W     = 16'(HDR_BYTES);

    state_e             state_reg;
    logic [7:0]         opcode_reg;
    logic [7:0]         len_lo_reg;
    logic [15:0]        cnt_reg;
    logic [3:0]         byte_idx_reg;
    logic               first_reg;
    logic               err_reg;
    logic [WIDTH_P-1:0] acc_reg;
    logic [WIDTH_P-1:0] operand_reg;

    logic               s_fire;
    logic [15:0]        len_w;
    logic [15:0]        rem_w;
    logic               len_bad;
    logic               op_alu;
    logic               alu_bad;
    logic               pay_last;
    logic               op_last;
    logic [WIDTH_P-1:0] operand_next;
    logic [WIDTH_P-1:0] acc_next;
    logic               err_load;
    logic               res_load;
    logic               echo_load;
    logic               ser_load;
    logic               ser_ready;
    logic               ser_done;
    logic [WIDTH_P-1:0] ser_word;
    logic [7:0]         ser_mode;

    assign s_fire   = s_axis_tvalid && s_axis_tready;
    assign len_w    = {s_axis_tdata, len_lo_reg};
    assign rem_w    = len_w - HDR_W;
    assign len_bad  = (len_w < HDR_W) || (len_w > MAX_LEN_W);
    assign op_alu   = (opcode_reg == OP_ADD) || (opcode_reg == OP_MUL);
    assign alu_bad  = (rem_w == 16'd0) || ((rem_w % NB_W) != 16'd0);
    assign pay_last = (cnt_reg == 16'd1);
    assign op_last  = s_fire && (state_reg == OPERAND) && (byte_idx_reg == NB_LAST);

    // Operand shift register: new bytes enter at the top lane so the first
    // received byte ends up least significant after NB shifts.
    genvar gi;
    generate
        for (gi = 0; gi < NB; gi++) begin : g_lane
            if (gi == NB - 1) begin : g_top
                assign operand_next[gi*8 +: 8] = s_axis_tdata;
            end else begin : g_mid
                assign operand_next[gi*8 +: 8] = operand_reg[(gi+1)*8 +: 8];
            end
        end
    endgenerate

    assign acc_next = first_reg              ? operand_next :
                      (opcode_reg == OP_MUL) ? acc_reg * operand_next :
                                               acc_reg + operand_next;

    always_comb begin
        err_load = 1'b0;
        if (s_fire) begin
            case (state_reg)
                LEN_HI: begin
                    if (len_bad) begin
                        err_load = 1'b1;
                    end else if (opcode_reg != OP_ECHO && (!op_alu || alu_bad)) begin
                        // Nothing left to drain: answer right away.
                        err_load = (rem_w == 16'd0);
                    end
                end
                DRAIN:   err_load = pay_last;
                default: err_load = 1'b0;
            endcase
        end
    end

    assign res_load  = op_last && pay_last;
    assign echo_load = s_fire && (state_reg == ECHO);
    assign ser_load  = err_load || res_load || echo_load;
    assign ser_word  = err_load ? WIDTH_P'(ERR_BYTE) :
                       res_load ? acc_next : WIDTH_P'(s_axis_tdata);
    assign ser_mode  = res_load ? MODE_WORD : MODE_BYTE;

    always_comb begin
        case (state_reg)
            ECHO:               s_axis_tready = (cnt_reg != 16'd0) && ser_ready;
            SEND_RES, SEND_ERR: s_axis_tready = 1'b0;
            default:            s_axis_tready = 1'b1;
        endcase
    end

    assign busy_o = (state_reg != IDLE_OP);
    assign err_o  = err_reg;

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_reg    <= IDLE_OP;
            opcode_reg   <= 8'h00;
            len_lo_reg   <= 8'h00;
            cnt_reg      <= 16'd0;
            byte_idx_reg <= 4'd0;
            first_reg    <= 1'b0;
            err_reg      <= 1'b0;
            acc_reg      <= '0;
            operand_reg  <= '0;
        end else begin
            err_reg <= err_load;
            case (state_reg)
                IDLE_OP: if (s_fire) begin
                    opcode_reg <= s_axis_tdata;
                    state_reg  <= RSVD;
                end
                RSVD: if (s_fire) state_reg <= LEN_LO;
                LEN_LO: if (s_fire) begin
                    len_lo_reg <= s_axis_tdata;
                    state_reg  <= LEN_HI;
                end
                LEN_HI: if (s_fire) begin
                    cnt_reg      <= rem_w;
                    byte_idx_reg <= 4'd0;
                    first_reg    <= 1'b1;
                    if (len_bad)
                        state_reg <= SEND_ERR;
                    else if (opcode_reg == OP_ECHO)
                        state_reg <= (rem_w == 16'd0) ? IDLE_OP : ECHO;
                    else if (op_alu && !alu_bad)
                        state_reg <= OPERAND;
                    else
                        state_reg <= (rem_w == 16'd0) ? SEND_ERR : DRAIN;
                end
                ECHO: begin
                    // Once all payload is in, wait for the last byte to leave.
                    if (s_fire)
                        cnt_reg <= cnt_reg - 16'd1;
                    else if (cnt_reg == 16'd0 && ser_done)
                        state_reg <= IDLE_OP;
                end
                OPERAND: if (s_fire) begin
                    cnt_reg     <= cnt_reg - 16'd1;
                    operand_reg <= operand_next;
                    if (byte_idx_reg == NB_LAST) begin
                        byte_idx_reg <= 4'd0;
                        first_reg    <= 1'b0;
                        acc_reg      <= acc_next;
                        if (pay_last) state_reg <= SEND_RES;
                    end else begin
                        byte_idx_reg <= byte_idx_reg + 4'd1;
                    end
                end
                SEND_RES, SEND_ERR: if (ser_done) state_reg <= IDLE_OP;
                DRAIN: if (s_fire) begin
                    cnt_reg <= cnt_reg - 16'd1;
                    if (pay_last) state_reg <= SEND_ERR;
                end
                default: state_reg <= IDLE_OP;
            endcase
        end
    end

    uart_alu_tx_ser #(
        .WIDTH_P(WIDTH_P)
    ) u_tx_ser (
        .clk_i        (clk_i),
        .reset_ni     (reset_ni),
        .load         (ser_load),
        .word         (ser_word),
        .mode         (ser_mode),
        .ready        (ser_ready),
        .done         (ser_done),
        .m_axis_tdata (m_axis_tdata),
        .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready)
    );

endmodule

// File: tb/tb_uart_alu_core.sv
// Bench for uart_alu_core: directed packets, random packets against a packet-level
// model, random/periodic output back-pressure and asynchronous reset mid-stream.
module tb_uart_alu_core;

    localparam int W      = 32;
    localparam int NBYTES = W / 8;
    localparam int BOUND  = 3000;

    typedef logic [7:0] bq_t [$];

    logic       clk_i    = 1'b0;
    logic       reset_ni = 1'b1;
    logic [7:0] s_axis_tdata;
    logic       s_axis_tvalid;
    logic       s_axis_tready;
    logic [7:0] m_axis_tdata;
    logic       m_axis_tvalid;
    logic       m_axis_tready;
    logic       busy_o;
    logic       err_o;

    int   checks      = 0;
    int   errors      = 0;
    int   cyc         = 0;
    int   tready_mode = 0;
    int   err_pulses  = 0;
    bq_t  out_q;
    logic prev_stall  = 1'b0;
    logic [7:0] prev_data = 8'h00;

    uart_alu_core #(
        .WIDTH_P  (W),
        .MAX_LEN_P(65535)
    ) dut (
        .clk_i        (clk_i),
        .reset_ni     (reset_ni),
        .s_axis_tdata (s_axis_tdata),
        .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tready(s_axis_tready),
        .m_axis_tdata (m_axis_tdata),
        .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready),
        .busy_o       (busy_o),
        .err_o        (err_o)
    );

    always #5 clk_i = ~clk_i;

    // Sink back-pressure: 0 always ready, 1 random, 2 one cycle in three, 3 stalled.
    always @(posedge clk_i) begin
        cyc++;
        #1;
        case (tready_mode)
            0:       m_axis_tready = 1'b1;
            1:       m_axis_tready = 1'($urandom_range(0, 1));
            2:       m_axis_tready = (cyc % 3 == 0);
            default: m_axis_tready = 1'b0;
        endcase
    end

    // Output monitor: collect accepted bytes, count err pulses, check hold-while-stalled.
    always @(negedge clk_i) begin
        if (reset_ni) begin
            if (prev_stall) begin
                checks++;
                assert (m_axis_tvalid === 1'b1 && m_axis_tdata === prev_data) else begin
                    errors++;
                    $error("FAIL hold: valid=%b data=%h, required valid=1 data=%h",
                           m_axis_tvalid, m_axis_tdata, prev_data);
                end
            end
            if (m_axis_tvalid && m_axis_tready) out_q.push_back(m_axis_tdata);
            if (err_o) err_pulses++;
            prev_stall = m_axis_tvalid && !m_axis_tready;
            prev_data  = m_axis_tdata;
        end else begin
            prev_stall = 1'b0;
        end
    end

    // Reference: expected response of one whole packet, from the framing rules.
    function automatic void model(input bq_t p, output bq_t exp, output int exp_err);
        int len;
        int rem;
        longint unsigned acc;
        longint unsigned x;
        longint unsigned mask;
        exp     = {};
        exp_err = 0;
        acc     = 0;
        mask    = (64'd1 << W) - 64'd1;
        len     = int'(p[2]) + 256 * int'(p[3]);
        rem     = len - 4;
        if (len < 4 || len > 65535) begin
            exp.push_back(8'hEE);
            exp_err = 1;
        end else if (p[0] == 8'hEC) begin
            for (int i = 4; i < len; i++) exp.push_back(p[i]);
        end else if ((p[0] == 8'hAD || p[0] == 8'h88) && rem > 0 && rem % NBYTES == 0) begin
            for (int k = 0; k < rem / NBYTES; k++) begin
                x = 0;
                for (int j = 0; j < NBYTES; j++) x += 64'(p[4 + k*NBYTES + j]) << (8*j);
                if (k == 0)              acc = x;
                else if (p[0] == 8'hAD)  acc = (acc + x) & mask;
                else                     acc = (acc * x) & mask;
            end
            for (int j = 0; j < NBYTES; j++) exp.push_back(8'((acc >> (8*j)) & 64'hFF));
        end else begin
            exp.push_back(8'hEE);
            exp_err = 1;
        end
    endfunction

    function automatic bq_t rand_pkt();
        bq_t        p;
        int         kind;
        int         len;
        int         r;
        logic [7:0] op;
        kind = $urandom_range(0, 6);
        op   = 8'hAD;
        len  = 4;
        case (kind)
            0: begin op = 8'hEC; len = 4 + $urandom_range(0, 8); end
            1: begin op = 8'hAD; len = 4 + NBYTES * $urandom_range(1, 4); end
            2: begin op = 8'h88; len = 4 + NBYTES * $urandom_range(1, 3); end
            3: begin
                op = 8'($urandom_range(0, 255));
                while (op == 8'hEC || op == 8'hAD || op == 8'h88) op = 8'($urandom_range(0, 255));
                len = 4 + $urandom_range(0, 6);
            end
            4: begin
                op = $urandom_range(0, 1) ? 8'hAD : 8'h88;
                r  = $urandom_range(1, 11);
                if (r % NBYTES == 0) r++;
                len = 4 + r;
            end
            5: begin op = 8'($urandom_range(0, 255)); len = $urandom_range(0, 3); end
            default: begin op = $urandom_range(0, 1) ? 8'hAD : 8'h88; len = 4; end
        endcase
        p = {op, 8'($urandom_range(0, 255)), 8'(len), 8'(len >> 8)};
        for (int i = 4; i < len; i++) p.push_back(8'($urandom_range(0, 255)));
        return p;
    endfunction

    // Called at a negedge; returns at the negedge following the transferring edge.
    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        s_axis_tdata  = b;
        s_axis_tvalid = 1'b1;
        while (s_axis_tready !== 1'b1 && n < BOUND) begin
            @(negedge clk_i);
            n++;
        end
        checks++;
        assert (n < BOUND) else begin
            errors++;
            $error("FAIL in_timeout: waited %0d cycles for s_axis_tready, required < %0d", n, BOUND);
        end
        @(negedge clk_i);
    endtask

    task automatic send_pkt(input bq_t p);
        foreach (p[i]) begin
            if ($urandom_range(0, 3) == 0) begin
                s_axis_tvalid = 1'b0;
                @(negedge clk_i);
            end
            send_byte(p[i]);
        end
        s_axis_tvalid = 1'b0;
    endtask

    task automatic run_pkt(input string tag, input bq_t p, input int mode);
        bq_t exp;
        int  exp_err;
        int  n;
        logic chk_now;
        model(p, exp, exp_err);
        out_q       = {};
        err_pulses  = 0;
        tready_mode = mode;
        chk_now     = (p[0] != 8'hEC) || (exp_err == 1);
        send_pkt(p);
        if (chk_now) begin
            checks++;
            assert (m_axis_tvalid === 1'b1 && m_axis_tdata === exp[0]) else begin
                errors++;
                $error("FAIL %s latency: valid=%b data=%h after last byte, required valid=1 data=%h",
                       tag, m_axis_tvalid, m_axis_tdata, exp[0]);
            end
        end
        n = 0;
        while ((out_q.size() < exp.size() || busy_o) && n < BOUND) begin
            @(negedge clk_i);
            n++;
        end
        repeat (4) @(negedge clk_i);
        checks++;
        assert (n < BOUND) else begin
            errors++;
            $error("FAIL %s out_timeout: got %0d bytes busy=%b, required %0d bytes", tag, out_q.size(), busy_o, exp.size());
        end
        checks++;
        assert (out_q.size() === exp.size()) else begin
            errors++;
            $error("FAIL %s count: got %0d bytes, required %0d", tag, out_q.size(), exp.size());
        end
        for (int i = 0; i < exp.size(); i++) begin
            if (i < out_q.size()) begin
                checks++;
                assert (out_q[i] === exp[i]) else begin
                    errors++;
                    $error("FAIL %s byte%0d: got %h, required %h", tag, i, out_q[i], exp[i]);
                end
            end
        end
        checks++;
        assert (err_pulses === exp_err) else begin
            errors++;
            $error("FAIL %s err_o: %0d pulses, required %0d", tag, err_pulses, exp_err);
        end
        checks++;
        assert (busy_o === 1'b0 && s_axis_tready === 1'b1) else begin
            errors++;
            $error("FAIL %s idle: busy=%b tready=%b, required busy=0 tready=1", tag, busy_o, s_axis_tready);
        end
        $display("pkt %-10s op=%h len=%0d mode=%0d in=%0d out=%0d exp=%0d err=%0d",
                 tag, p[0], int'(p[2]) + 256 * int'(p[3]), mode, p.size(), out_q.size(), exp.size(), err_pulses);
    endtask

    task automatic chk_reset(input string tag);
        checks++;
        assert (m_axis_tvalid === 1'b0 && busy_o === 1'b0 && s_axis_tready === 1'b1 && err_o === 1'b0)
        else begin
            errors++;
            $error("FAIL %s: tvalid=%b busy=%b tready=%b err=%b, required 0 0 1 0",
                   tag, m_axis_tvalid, busy_o, s_axis_tready, err_o);
        end
    endtask

    initial begin
        bq_t p;
        s_axis_tvalid = 1'b0;
        s_axis_tdata  = 8'h00;
        m_axis_tready = 1'b1;
        #2 reset_ni = 1'b0;
        repeat (3) @(negedge clk_i);
        chk_reset("reset_state");
        checks++;
        assert (m_axis_tdata === 8'h00) else begin
            errors++;
            $error("FAIL reset_tdata: got %h, required 00", m_axis_tdata);
        end
        reset_ni = 1'b1;
        @(negedge clk_i);

        p = {8'hAD, 8'h00, 8'h0C, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h02, 8'h00, 8'h00, 8'h00};
        run_pkt("add", p, 0);
        p = {8'h88, 8'h00, 8'h0C, 8'h00, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h02, 8'h00, 8'h00, 8'h00};
        run_pkt("mul_wrap", p, 0);
        run_pkt("mul_bp", p, 2);
        p = {8'hEC, 8'h00, 8'h06, 8'h00, 8'h48, 8'h69};
        run_pkt("echo", p, 0);
        p = {8'hEC, 8'h00, 8'h04, 8'h00};
        run_pkt("echo_empty", p, 0);
        p = {8'h55, 8'h00, 8'h06, 8'h00, 8'hAA, 8'hBB};
        run_pkt("bad_op", p, 0);
        p = {8'hAD, 8'h00, 8'h08, 8'h00, 8'h07, 8'h00, 8'h00, 8'h00};
        run_pkt("after_bad", p, 0);
        p = {8'hAD, 8'h00, 8'h05, 8'h00, 8'h11};
        run_pkt("len5", p, 0);
        p = {8'hAD, 8'h00, 8'h03, 8'h00};
        run_pkt("len3", p, 1);

        for (int t = 0; t < 40; t++) begin
            p = rand_pkt();
            run_pkt($sformatf("rnd%0d", t), p, $urandom_range(0, 2));
        end

        // Reset in the middle of an incoming packet.
        tready_mode = 0;
        p = {8'hAD, 8'h00, 8'h0C, 8'h00, 8'h01, 8'h00};
        send_pkt(p);
        #1 reset_ni = 1'b0;
        #1 chk_reset("rst_mid_pkt");
        repeat (2) @(negedge clk_i);
        reset_ni = 1'b1;
        @(negedge clk_i);
        p = {8'hAD, 8'h00, 8'h08, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00};
        run_pkt("rst_next", p, 0);

        // Reset while a result is stalled at the output.
        p = {8'h88, 8'h00, 8'h0C, 8'h00, 8'h03, 8'h00, 8'h00, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00};
        tready_mode = 3;
        send_pkt(p);
        repeat (3) @(negedge clk_i);
        checks++;
        assert (m_axis_tvalid === 1'b1 && m_axis_tdata === 8'h0F) else begin
            errors++;
            $error("FAIL stalled_res: valid=%b data=%h, required valid=1 data=0f", m_axis_tvalid, m_axis_tdata);
        end
        #1 reset_ni = 1'b0;
        #1 chk_reset("rst_mid_tx");
        repeat (2) @(negedge clk_i);
        reset_ni = 1'b1;
        @(negedge clk_i);
        p = {8'hEC, 8'h00, 8'h07, 8'h00, 8'h01, 8'h02, 8'h03};
        run_pkt("rst_echo", p, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
